// File: rtl/i2s_pkg.sv
// Shared I2S constants for the ADC receive and DAC transmit sides.
// Defaults assume a 100 MHz core clock, a 16 kHz frame rate and 24-bit slots.
package i2s_pkg;

    localparam int I2S_SLOT_BITS    = 24;
    localparam int I2S_BCK_HALF_DIV = 65;

    function automatic int i2s_frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction

    localparam int I2S_FRAME_BITS = i2s_frame_bits(I2S_SLOT_BITS);

endpackage

// File: rtl/i2s_rx_shifter.sv
// Per-channel I2S capture: 2-flop din synchronizer, MSB-first shift register, completion strobe.
// Latency: word_dat/word_done are combinational on the final sample cycle; no backpressure.
// The owner registers or drops the word on word_done.
module i2s_rx_shifter #(
    parameter int SLOT_BITS = 24
) (
    input  logic                 cmn_clk,
    input  logic                 cmn_rst_n,
    input  logic                 adc_din,
    input  logic                 sample_en,
    input  logic                 shift_en,
    input  logic                 last_bit,
    output logic                 word_done,
    output logic [SLOT_BITS-1:0] word_dat
);

    logic                 din_sync1;
    logic                 din_sync2;
    logic [SLOT_BITS-1:0] shreg;

    always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
        if (!cmn_rst_n) begin
            din_sync1 <= 1'b0;
            din_sync2 <= 1'b0;
            shreg     <= '0;
        end else begin
            din_sync1 <= adc_din;
            din_sync2 <= din_sync1;
            if (sample_en && shift_en) begin
                shreg <= word_dat;
            end
        end
    end

    // The completed word includes the bit being sampled this cycle.
    assign word_dat  = {shreg[SLOT_BITS-2:0], din_sync2};
    assign word_done = sample_en && shift_en && last_bit;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S master receiver: generates BCK/LRCK, captures left/right words into two valid/ready streams.
// Latency: word presented the cycle after its last bit is sampled (2 cycles after the BCK rise).
// Backpressure: a word completing while its stream is still valid is dropped and sets sticky overrun.
// Optional I2S_RX_OVF_CNT_EN adds a 16-bit saturating dropped-word counter ovf_count.
module i2s_adc_receiver
    import i2s_pkg::*;
#(
    parameter int BCK_HALF_DIV = I2S_BCK_HALF_DIV,
    parameter int SLOT_BITS    = I2S_SLOT_BITS
) (
    input  logic                 cmn_clk,
    input  logic                 cmn_rst_n,
    input  logic                 adc_din,
    output logic                 adc_bck,
    output logic                 adc_lrck,
    output logic                 tvalid_LC_audio,
    output logic [SLOT_BITS-1:0] LC_audio,
    input  logic                 tready_LC_audio,
    output logic                 tvalid_RC_audio,
    output logic [SLOT_BITS-1:0] RC_audio,
    input  logic                 tready_RC_audio,
    output logic                 overrun
`ifdef I2S_RX_OVF_CNT_EN
    ,
    output logic [15:0]          ovf_count
`endif
);

    localparam int FRAME_BITS = i2s_frame_bits(SLOT_BITS);
    localparam int PW         = $clog2(FRAME_BITS);
    localparam int DW         = $clog2(BCK_HALF_DIV + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_HALF_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] POS_SLOT = PW'(SLOT_BITS);

    logic [DW-1:0] div_cnt;
    logic [PW-1:0] bit_pos;
    logic [PW-1:0] pos_next;
    logic          div_wrap;
    logic          bck_rise;
    logic          bck_fall;
    logic          rise_d1;
    logic          sample_en;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign bck_rise = div_wrap && !adc_bck;
    assign bck_fall = div_wrap && adc_bck;
    assign pos_next = (bit_pos == POS_LAST) ? '0 : bit_pos + PW'(1);

    always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
        if (!cmn_rst_n) begin
            div_cnt   <= '0;
            adc_bck   <= 1'b0;
            adc_lrck  <= 1'b0;
            bit_pos   <= '0;
            rise_d1   <= 1'b0;
            sample_en <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
                adc_bck <= !adc_bck;
            end
            if (bck_fall) begin
                bit_pos  <= pos_next;
                adc_lrck <= (pos_next >= POS_SLOT);
            end
            // Two-cycle delay matches the din synchronizer depth.
            rise_d1   <= bck_rise;
            sample_en <= rise_d1;
        end
    end

    // Left slot holds p=1..SLOT_BITS; everything else (including p=0) belongs to the right word.
    logic                 l_shift;
    logic                 l_last;
    logic                 r_shift;
    logic                 r_last;
    logic                 l_done;
    logic                 r_done;
    logic [SLOT_BITS-1:0] l_word;
    logic [SLOT_BITS-1:0] r_word;

    assign l_shift = (bit_pos != '0) && (bit_pos <= POS_SLOT);
    assign l_last  = (bit_pos == POS_SLOT);
    assign r_shift = !l_shift;
    assign r_last  = (bit_pos == '0);

    i2s_rx_shifter #(
        .SLOT_BITS (SLOT_BITS)
    ) u_left_shifter (
        .cmn_clk   (cmn_clk),
        .cmn_rst_n (cmn_rst_n),
        .adc_din   (adc_din),
        .sample_en (sample_en),
        .shift_en  (l_shift),
        .last_bit  (l_last),
        .word_done (l_done),
        .word_dat  (l_word)
    );

    i2s_rx_shifter #(
        .SLOT_BITS (SLOT_BITS)
    ) u_right_shifter (
        .cmn_clk   (cmn_clk),
        .cmn_rst_n (cmn_rst_n),
        .adc_din   (adc_din),
        .sample_en (sample_en),
        .shift_en  (r_shift),
        .last_bit  (r_last),
        .word_done (r_done),
        .word_dat  (r_word)
    );

    logic left_seen;
    logic lc_load;
    logic lc_drop;
    logic rc_emit;
    logic rc_load;
    logic rc_drop;

    // A handshake in the completion cycle frees the slot, so the new word loads instead of dropping.
    assign lc_load = l_done && (!tvalid_LC_audio || tready_LC_audio);
    assign lc_drop = l_done && !lc_load;
    assign rc_emit = r_done && left_seen;
    assign rc_load = rc_emit && (!tvalid_RC_audio || tready_RC_audio);
    assign rc_drop = rc_emit && !rc_load;

    always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
        if (!cmn_rst_n) begin
            tvalid_LC_audio <= 1'b0;
            LC_audio        <= '0;
            tvalid_RC_audio <= 1'b0;
            RC_audio        <= '0;
            left_seen       <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            if (lc_load) begin
                LC_audio        <= l_word;
                tvalid_LC_audio <= 1'b1;
            end else if (tvalid_LC_audio && tready_LC_audio) begin
                tvalid_LC_audio <= 1'b0;
            end

            if (rc_load) begin
                RC_audio        <= r_word;
                tvalid_RC_audio <= 1'b1;
            end else if (tvalid_RC_audio && tready_RC_audio) begin
                tvalid_RC_audio <= 1'b0;
            end

            // Right words pair with the preceding left word; a partial frame after reset is discarded.
            if (l_done) begin
                left_seen <= 1'b1;
            end else if (r_done) begin
                left_seen <= 1'b0;
            end

            if (lc_drop || rc_drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef I2S_RX_OVF_CNT_EN
    always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
        if (!cmn_rst_n) begin
            ovf_count <= '0;
        end else if ((lc_drop || rc_drop) && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule
